// File: rtl/heater_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : heater_pkg
//  Description : Shared types, default parameter values and helper functions
//                for the heater array controller.
//  Revision    : 1.0  initial release
// ============================================================================
package heater_pkg;

  // Default parameter values for the controller
  localparam int unsigned C_N_DEFAULT       = 18;
  localparam int unsigned C_DUTY_W_DEFAULT  = 8;
  localparam int unsigned C_RAMP_DEFAULT    = 1024;
  localparam int unsigned C_STAGGER_DEFAULT = 13;
  localparam int unsigned C_CNT_W_DEFAULT   = 16;
  localparam int unsigned C_WDOG_DEFAULT    = 32'd1 << 24;

  // Ramp FSM state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_e;

  // Index of the lowest set bit; returns 0 when no bit is set
  function automatic int unsigned lowest_set_idx(input logic [63:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Number of set bits in a 64-bit vector
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heater_pwm_chan.sv
`default_nettype none
// ============================================================================
//  Module      : heater_pwm_chan
//  Description : One heater channel: phase-offset PWM compare against the
//                shared counter, gated by the staged enable and registered.
//  Revision    : 1.0  initial release
// ============================================================================
module heater_pwm_chan
  import heater_pkg::*;
#(
  parameter int unsigned DUTY_W  = C_DUTY_W_DEFAULT,
  parameter int unsigned CHAN    = 0,
  parameter int unsigned STAGGER = C_STAGGER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic [DUTY_W-1:0] duty,
  input  logic              staged,
  output logic              heater_enable
);

  // Phase offset of this channel, wrapped to the counter width
  localparam logic [DUTY_W-1:0] C_OFFSET = DUTY_W'(CHAN * STAGGER);

  logic [DUTY_W-1:0] w_phase;
  logic              w_pwm_on;
  logic              heater_enable_d;
  logic              heater_enable_q;

  // Phase compare; an all-ones duty keeps the channel on continuously
  always_comb begin
    w_phase         = pwm_cnt + C_OFFSET;
    w_pwm_on        = (&duty) | (w_phase < duty);
    heater_enable_d = staged & w_pwm_on;
  end

  // Output register so the heater gate never sees combinational glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heater_enable_q <= 1'b0;
    end else begin
      heater_enable_q <= heater_enable_d;
    end
  end

  assign heater_enable = heater_enable_q;

endmodule
`default_nettype wire

// File: rtl/heater_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : heater_array_ctrl
//  Description : Staged turn-on controller for N heater channels with
//                phase-staggered PWM, sticky per-channel error latching and a
//                saturating error event counter.
//                Optional watchdog compiled in with `define HEATER_WATCHDOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module heater_array_ctrl
  import heater_pkg::*;
#(
  parameter int unsigned N           = C_N_DEFAULT,
  parameter int unsigned DUTY_W      = C_DUTY_W_DEFAULT,
  parameter int unsigned RAMP_CYCLES = C_RAMP_DEFAULT,
  parameter int unsigned STAGGER     = C_STAGGER_DEFAULT,
  parameter int unsigned CNT_W       = C_CNT_W_DEFAULT,
  parameter int unsigned WDOG_CYCLES = C_WDOG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      enable_req,
  input  logic [DUTY_W-1:0] duty,
  input  logic [N-1:0]      err_clear,
  input  logic [N-1:0]      heater_error,
`ifdef HEATER_WATCHDOG_EN
  input  logic              wdog_kick,
  output logic              wdog_trip,
`endif
  output logic [N-1:0]      heater_enable,
  output logic [N-1:0]      heater_err_clear,
  output logic [N-1:0]      err_latched,
  output logic [CNT_W-1:0]  err_count,
  output logic              ramping
);

  localparam int unsigned       RAMP_W      = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [RAMP_W-1:0] C_RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
  localparam int unsigned       SUM_W       = CNT_W + 8;
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  ramp_state_e       state_q, state_d;
  logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [N-1:0]      staged_q, staged_d;
  logic [N-1:0]      err_latched_q, err_latched_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [N-1:0]      err_clr_q, err_clr_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;

  logic [N-1:0]      w_target;
  logic [N-1:0]      w_pending;
  logic [N-1:0]      w_pick;
  int unsigned       w_pick_idx;
  logic [N-1:0]      w_rise;
  logic [SUM_W-1:0]  w_sum;
  logic              w_trip;

  // ---------------------------------------------------------------------------
  // Optional watchdog: missing kicks for WDOG_CYCLES holds every channel off
  // ---------------------------------------------------------------------------
`ifdef HEATER_WATCHDOG_EN
  localparam int unsigned       WDOG_W      = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_trip_q, wdog_trip_d;

  // Watchdog counter: a kick restarts it and releases a trip
  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    wdog_trip_d = wdog_trip_q;
    if (wdog_kick) begin
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b0;
    end else if (!wdog_trip_q) begin
      if (wdog_cnt_q == C_WDOG_LAST) begin
        wdog_cnt_d  = '0;
        wdog_trip_d = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
      end
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign w_trip    = wdog_trip_q;
  assign wdog_trip = wdog_trip_q;
`else
  assign w_trip = 1'b0;
`endif

  // Channels that may be on, and those still waiting for their ramp slot
  always_comb begin
    w_target   = enable_req & ~err_latched_q & ~{N{w_trip}};
    w_pending  = w_target & ~staged_q;
    w_pick_idx = lowest_set_idx(64'(w_pending));
    w_pick     = '0;
    for (int i = 0; i < N; i++) begin
      w_pick[i] = (w_pick_idx == i);
    end
  end

  // Ramp FSM state register; also holds the ramp counter and staged mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ramp_cnt_q <= '0;
      staged_q   <= '0;
    end else begin
      state_q    <= state_d;
      ramp_cnt_q <= ramp_cnt_d;
      staged_q   <= staged_d;
    end
  end

  // Ramp FSM next state: turn-off is immediate, turn-on one channel per slot
  always_comb begin
    state_d    = state_q;
    ramp_cnt_d = ramp_cnt_q;
    staged_d   = staged_q & w_target;
    case (state_q)
      ST_IDLE: begin
        if (|w_pending) begin
          state_d    = ST_RAMP;
          ramp_cnt_d = '0;
        end
      end
      ST_RAMP: begin
        if (!(|w_pending)) begin
          state_d    = ST_IDLE;
          ramp_cnt_d = '0;
        end else if (ramp_cnt_q == C_RAMP_LAST) begin
          staged_d   = staged_d | w_pick;
          ramp_cnt_d = '0;
          if (!(|(w_pending & ~w_pick))) begin
            state_d = ST_IDLE;
          end
        end else begin
          ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ramp_cnt_d = '0;
      end
    endcase
    if (w_trip) begin
      staged_d = '0;
    end
  end

  // Ramp FSM outputs
  always_comb begin
    ramping = (state_q == ST_RAMP);
  end

  // Error latch (set wins over clear), saturating rise counter, pwm counter
  always_comb begin
    err_latched_d = (err_latched_q & ~(err_clear & ~heater_error)) | heater_error;
    w_rise        = err_latched_d & ~err_latched_q;
    w_sum         = SUM_W'(err_count_q) + SUM_W'(popcount64(64'(w_rise)));
    err_count_d   = (w_sum > SUM_W'(C_CNT_MAX)) ? C_CNT_MAX : w_sum[CNT_W-1:0];
    err_clr_d     = err_clear;
    pwm_cnt_d     = pwm_cnt_q + DUTY_W'(1);
  end

  // Error, clear-forwarding and pwm counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_latched_q <= '0;
      err_count_q   <= '0;
      err_clr_q     <= '0;
      pwm_cnt_q     <= '0;
    end else begin
      err_latched_q <= err_latched_d;
      err_count_q   <= err_count_d;
      err_clr_q     <= err_clr_d;
      pwm_cnt_q     <= pwm_cnt_d;
    end
  end

  // Per-channel phase compare and registered gate
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    heater_pwm_chan #(
      .DUTY_W  (DUTY_W),
      .CHAN    (gi),
      .STAGGER (STAGGER)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .pwm_cnt       (pwm_cnt_q),
      .duty          (duty),
      .staged        (staged_q[gi]),
      .heater_enable (heater_enable[gi])
    );
  end

  assign heater_err_clear = err_clr_q;
  assign err_latched      = err_latched_q;
  assign err_count        = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_heater_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_heater_array_ctrl
//  Description : Self-checking bench for heater_array_ctrl with a cycle-level
//                behavioural reference model and randomized stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_heater_array_ctrl;

  localparam int unsigned N       = 3;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned RAMP    = 4;
  localparam int unsigned STAGGER = 13;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      enable_req = '0;
  logic [DUTY_W-1:0] duty = '0;
  logic [N-1:0]      err_clear = '0;
  logic [N-1:0]      heater_error = '0;
  logic [N-1:0]      heater_enable;
  logic [N-1:0]      heater_err_clear;
  logic [N-1:0]      err_latched;
  logic [CNT_W-1:0]  err_count;
  logic              ramping;
`ifdef HEATER_WATCHDOG_EN
  logic              wdog_kick = 1'b0;
  logic              wdog_trip;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef HEATER_WATCHDOG_EN
  // Keep the watchdog fed; it is not exercised by this bench
  always @(negedge clk) wdog_kick = ~wdog_kick;
`endif

  heater_array_ctrl #(
    .N(N), .DUTY_W(DUTY_W), .RAMP_CYCLES(RAMP), .STAGGER(STAGGER),
    .CNT_W(CNT_W), .WDOG_CYCLES(1 << 24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_req(enable_req), .duty(duty),
    .err_clear(err_clear), .heater_error(heater_error),
`ifdef HEATER_WATCHDOG_EN
    .wdog_kick(wdog_kick), .wdog_trip(wdog_trip),
`endif
    .heater_enable(heater_enable), .heater_err_clear(heater_err_clear),
    .err_latched(err_latched), .err_count(err_count), .ramping(ramping)
  );

  // ---------------------------------------------------------------------------
  // Reference model: per-channel bits, integer timers and counters
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_staged, m_err, m_en, m_clr;
  int           m_cnt, m_pwm, m_elapsed;
  bit           m_ramp;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] pend, nerr, keep, en;
    int rises, pick;
    if (!rst_n) begin
      m_staged <= '0; m_err <= '0; m_en <= '0; m_clr <= '0;
      m_cnt <= 0; m_pwm <= 0; m_elapsed <= 0; m_ramp <= 1'b0;
    end else begin
      pend = enable_req & ~m_err & ~m_staged;
      nerr = (m_err & ~(err_clear & ~heater_error)) | heater_error;
      rises = 0;
      for (int i = 0; i < N; i++) if (nerr[i] && !m_err[i]) rises++;
      for (int i = 0; i < N; i++)
        en[i] = m_staged[i] && (duty == 8'hFF || ((m_pwm + i * STAGGER) % 256) < int'(duty));
      keep = m_staged & enable_req & ~m_err;
      if (!m_ramp) begin
        if (pend != 0) begin m_ramp <= 1'b1; m_elapsed <= 0; end
      end else if (pend == 0) begin
        m_ramp <= 1'b0; m_elapsed <= 0;
      end else if (m_elapsed == RAMP - 1) begin
        pick = 0;
        for (int i = N - 1; i >= 0; i--) if (pend[i]) pick = i;
        keep[pick] = 1'b1;
        pend[pick] = 1'b0;
        m_elapsed <= 0;
        m_ramp <= (pend != 0);
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
      m_cnt    <= (m_cnt + rises > CNT_MAX) ? CNT_MAX : m_cnt + rises;
      m_en     <= en;
      m_staged <= keep;
      m_err    <= nerr;
      m_clr    <= err_clear;
      m_pwm    <= (m_pwm + 1) % 256;
    end
  end

  wire [3*N+CNT_W:0] act_v = {heater_enable, heater_err_clear, err_latched, err_count, ramping};
  wire [3*N+CNT_W:0] exp_v = {m_en, m_clr, m_err, CNT_W'(m_cnt), m_ramp};

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (act_v !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", act_v);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", act_v, exp_v);
    end
  endtask

  // Staged turn-on: lowest index first, one channel per RAMP cycles
  task automatic test_ramp();
    logic [N-1:0] want;
    enable_req = 3'b111;
    duty = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      want = {k >= 13, k >= 9, k >= 5};
      n_cmp++;
      if (heater_enable !== want || ramping !== (k < 12)) begin
        n_fail++;
        $display("FAIL ramp k=%0d: got en=%b ramp=%b want en=%b ramp=%b",
                 k, heater_enable, ramping, want, k < 12);
      end
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL ramp_model k=%0d: got %h want %h", k, act_v, exp_v);
      end
    end
  endtask

  // Dropping one request turns only that channel off, two edges later
  task automatic test_turn_off();
    enable_req = 3'b101;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_cmp++;
      if (heater_enable !== ((j == 1) ? 3'b111 : 3'b101)) begin
        n_fail++; $display("FAIL turn_off j=%0d: got %b", j, heater_enable);
      end
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL turn_off_model j=%0d: got %h want %h", j, act_v, exp_v);
      end
    end
  endtask

  // One-cycle error pulse latches, counts once and removes the channel
  task automatic test_error_pulse();
    heater_error = 3'b100;
    @(negedge clk);
    heater_error = '0;
    n_cmp++;
    if (err_latched[2] !== 1'b1 || err_count !== 4'd1) begin
      n_fail++; $display("FAIL err_pulse: got lat=%b cnt=%0d want lat[2]=1 cnt=1", err_latched, err_count);
    end
    for (int j = 2; j <= 4; j++) begin
      @(negedge clk);
      n_cmp++;
      if (heater_enable[2] !== (j == 2)) begin
        n_fail++; $display("FAIL err_off j=%0d: got %b want %b", j, heater_enable[2], j == 2);
      end
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL err_model j=%0d: got %h want %h", j, act_v, exp_v);
      end
    end
  endtask

  // Clear and error together: the latch stays set
  task automatic test_err_set_wins();
    heater_error = 3'b100;
    err_clear = 3'b100;
    @(negedge clk);
    heater_error = '0;
    err_clear = '0;
    n_cmp++;
    if (err_latched[2] !== 1'b1 || heater_err_clear !== 3'b100 || err_count !== 4'd1) begin
      n_fail++;
      $display("FAIL set_wins: got lat=%b clr=%b cnt=%0d want lat[2]=1 clr=100 cnt=1",
               err_latched, heater_err_clear, err_count);
    end
  endtask

  // Clear without error releases the channel, which then re-ramps
  task automatic test_err_clear();
    err_clear = 3'b100;
    @(negedge clk);
    err_clear = '0;
    n_cmp++;
    if (err_latched[2] !== 1'b0 || heater_err_clear !== 3'b100) begin
      n_fail++; $display("FAIL err_clear: got lat=%b clr=%b", err_latched, heater_err_clear);
    end
    for (int j = 2; j <= 9; j++) begin
      @(negedge clk);
      n_cmp++;
      if (heater_enable[2] !== (j >= 7) || heater_err_clear !== 3'b000) begin
        n_fail++;
        $display("FAIL reramp j=%0d: got en2=%b clr=%b want en2=%b clr=000",
                 j, heater_enable[2], heater_err_clear, j >= 7);
      end
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL reramp_model j=%0d: got %h want %h", j, act_v, exp_v);
      end
    end
    enable_req = 3'b111;
    repeat (8) begin
      @(negedge clk);
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL reenable_model: got %h want %h", act_v, exp_v);
      end
    end
  endtask

  // duty = 64: 64 of 256 cycles high, phase offset of i*STAGGER per channel
  task automatic test_pwm();
    int highs [N];
    int rise [N];
    logic [N-1:0] prev;
    duty = 8'd64;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin highs[i] = 0; rise[i] = -1; end
    prev = heater_enable;
    for (int j = 1; j <= 256; j++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (heater_enable[i]) highs[i]++;
        if (heater_enable[i] && !prev[i]) rise[i] = j;
      end
      prev = heater_enable;
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL pwm_model j=%0d: got %h want %h", j, act_v, exp_v);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (highs[i] != 64) begin
        n_fail++; $display("FAIL pwm_highs ch%0d: got %0d want 64", i, highs[i]);
      end
      n_cmp++;
      if ((rise[i] - rise[0] + 256) % 256 != (256 - (i * STAGGER) % 256) % 256) begin
        n_fail++;
        $display("FAIL pwm_phase ch%0d: got offset %0d want %0d", i,
                 (rise[i] - rise[0] + 256) % 256, (256 - (i * STAGGER) % 256) % 256);
      end
    end
  endtask

  // Duty extremes: 0 never on, all-ones always on
  task automatic test_duty_bounds();
    duty = 8'd0;
    repeat (2) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (heater_enable !== 3'b000 || act_v !== exp_v) begin
        n_fail++; $display("FAIL duty0: got %h want %h", act_v, exp_v);
      end
    end
    duty = 8'hFF;
    @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (heater_enable !== 3'b111 || act_v !== exp_v) begin
        n_fail++; $display("FAIL duty_ff: got %h want %h", act_v, exp_v);
      end
    end
  endtask

  // Simultaneous rises add together and the counter saturates
  task automatic test_count_sat();
    int want;
    for (int r = 1; r <= 5; r++) begin
      heater_error = 3'b111;
      @(negedge clk);
      heater_error = '0;
      err_clear = 3'b111;
      want = (1 + 3 * r > CNT_MAX) ? CNT_MAX : 1 + 3 * r;
      n_cmp++;
      if (err_count !== CNT_W'(want) || act_v !== exp_v) begin
        n_fail++; $display("FAIL err_count r=%0d: got %0d want %0d", r, err_count, want);
      end
      @(negedge clk);
      err_clear = '0;
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL err_count_clear r=%0d: got %h want %h", r, act_v, exp_v);
      end
    end
  endtask

  // Randomized traffic against the reference model
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL random c=%0d: got %h want %h", c, act_v, exp_v);
      end
      if ($urandom_range(0, 19) == 0) enable_req = N'($urandom);
      case ($urandom_range(0, 30))
        0: duty = 8'h00;
        1: duty = 8'hFF;
        2: duty = 8'($urandom);
        default: ;
      endcase
      heater_error = ($urandom_range(0, 40) == 0) ? N'($urandom) : '0;
      err_clear    = ($urandom_range(0, 10) == 0) ? N'($urandom) : '0;
    end
    heater_error = '0;
    err_clear = '0;
  endtask

  // Reset mid-ramp drops staged channels; the ramp restarts from scratch
  task automatic test_reset_mid_ramp();
    enable_req = '0;
    err_clear = 3'b111;
    duty = 8'hFF;
    @(negedge clk);
    err_clear = '0;
    repeat (3) @(negedge clk);
    enable_req = 3'b111;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (act_v !== '0) begin
      n_fail++; $display("FAIL mid_ramp_reset: got %h want 0", act_v);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      n_cmp++;
      if (heater_enable !== {k >= 13, k >= 9, k >= 5} || act_v !== exp_v) begin
        n_fail++; $display("FAIL ramp_after_reset k=%0d: got %h want %h", k, act_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_turn_off();
    test_error_pulse();
    test_err_set_wins();
    test_err_clear();
    test_pwm();
    test_duty_bounds();
    test_count_sat();
    test_random();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
